point_unpacker: RTL

POINT_UNPACKER -- requirements
Module: point_unpacker

---
 rtl/point_unpacker.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/point_unpacker.sv
// point_unpacker: turns a byte stream of Ethernet frames into 64-bit point
// records. HDR_BYTES header bytes are skipped, then every 8 payload bytes
// are packed MSB first into one record and pushed into a small FIFO.
// Optional feature: define POINT_UNPACKER_ETHERTYPE_CHECK_EN to drop frames
// whose EtherType (header bytes 12-13) differs from ETHERTYPE.
module point_unpacker #(
    parameter int          HDR_BYTES  = 14,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    input  logic        rx_last_in,
    output logic [63:0] point_out,
    output logic        point_valid_out,
    input  logic        point_ready_in,
    output logic        marker_out,
    output logic [15:0] drop_count_out,
    output logic        busy_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(HDR_BYTES) + 1;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    logic          rst_meta_q;
    logic          rst_sync_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [63:8]   asm_q, asm_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [63:0]   rec_s;
    logic          push_s;
    logic          frame_drop_s;
    logic          etype_bad_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          ovf_s;

    // Reset synchroniser: assert immediately, release after two clock edges.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

`ifdef POINT_UNPACKER_ETHERTYPE_CHECK_EN
    logic [7:0] etype_hi_q, etype_hi_d;

    // Capture the EtherType high byte (header byte 12).
    always_comb begin
        etype_hi_d = etype_hi_q;
        if (rx_valid_in && (state_q == ST_HEADER) && (cnt_q == CW'(12))) begin
            etype_hi_d = rx_data_in;
        end else begin
            etype_hi_d = etype_hi_q;
        end
    end

    // EtherType high byte register.
    always_ff @(posedge clock_in or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            etype_hi_q <= 8'h00;
        end else begin
            etype_hi_q <= etype_hi_d;
        end
    end

    assign etype_bad_s = (HDR_BYTES > 13) && (cnt_q == CW'(13)) &&
                         ({etype_hi_q, rx_data_in} != ETHERTYPE);
`else
    logic unused_etype_s;
    assign unused_etype_s = ^ETHERTYPE;
    assign etype_bad_s    = 1'b0;
`endif

    // Frame parser: header skip, MSB-first record assembly, drop handling.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        push_s       = 1'b0;
        frame_drop_s = 1'b0;
        rec_s        = {asm_q, rx_data_in};
        if (rx_valid_in) begin
            case (state_q)
                ST_HEADER: begin
                    if (rx_last_in) begin
                        state_d      = ST_HEADER;
                        cnt_d        = {CW{1'b0}};
                        frame_drop_s = 1'b1;
                    end else if (etype_bad_s) begin
                        state_d      = ST_DROP;
                        cnt_d        = {CW{1'b0}};
                        frame_drop_s = 1'b1;
                    end else if (cnt_q == CW'(HDR_BYTES - 1)) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = {CW{1'b0}};
                        idx_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PAYLOAD: begin
                    if (idx_q == 3'd7) begin
                        push_s = 1'b1;
                        idx_d  = 3'd0;
                    end else begin
                        case (idx_q)
                            3'd0:    asm_d[63:56] = rx_data_in;
                            3'd1:    asm_d[55:48] = rx_data_in;
                            3'd2:    asm_d[47:40] = rx_data_in;
                            3'd3:    asm_d[39:32] = rx_data_in;
                            3'd4:    asm_d[31:24] = rx_data_in;
                            3'd5:    asm_d[23:16] = rx_data_in;
                            3'd6:    asm_d[15:8]  = rx_data_in;
                            default: asm_d        = asm_q;
                        endcase
                        idx_d = idx_q + 3'd1;
                    end
                    if (rx_last_in) begin
                        // A last byte that does not complete a record discards
                        // the bytes already assembled.
                        state_d      = ST_HEADER;
                        cnt_d        = {CW{1'b0}};
                        idx_d        = 3'd0;
                        frame_drop_s = (idx_q != 3'd0) && (idx_q != 3'd7);
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_DROP: begin
                    if (rx_last_in) begin
                        state_d = ST_HEADER;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_HEADER;
                    cnt_d   = {CW{1'b0}};
                    idx_d   = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO control; a full FIFO still accepts a push when the head pops.
    always_comb begin
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s    = !empty_s && point_ready_in;
        wr_en_s  = push_s && (!full_s || pop_s);
        ovf_s    = push_s && full_s && !pop_s;
        wr_ptr_d = wr_en_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
        // Coincident drop events count once; the counter saturates.
        if ((frame_drop_s || ovf_s) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge clock_in or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= ST_HEADER;
            cnt_q      <= {CW{1'b0}};
            idx_q      <= 3'd0;
            asm_q      <= 56'h0;
            wr_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q   <= {(AW+1){1'b0}};
            drop_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage; contents are only visible through a valid head.
    always_ff @(posedge clock_in) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec_s;
        end
    end

    assign point_valid_out = !empty_s;
    assign point_out       = empty_s ? 64'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign marker_out      = !empty_s && (point_out == 64'hFFFF_FFFF_FFFF_FFFF);
    assign drop_count_out  = drop_cnt_q;
    assign busy_out        = (state_q != ST_HEADER) || (cnt_q != {CW{1'b0}}) || !empty_s;

endmodule
